// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: rounding-mode encodings and saturation limits.
package fixed_point_pkg;

  localparam logic ROUND_TRUNC   = 1'b0;
  localparam logic ROUND_HALF_UP = 1'b1;

  // Widest word the limit helpers can describe; callers slice the low bits.
  localparam int MAX_W = 256;

  function automatic logic [MAX_W-1:0] sat_pos_limit(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_neg_limit(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/convert_fixed_point_shrink_lane.sv
// One lane of the fixed-point shrink: drop fraction bits (floor or half-up), then saturate.
module convert_fixed_point_shrink_lane
  import fixed_point_pkg::*;
#(
  parameter int X_DATA_WIDTH     = 47,
  parameter int X_DATA_WIDTH_INT = 5,
  parameter int Y_DATA_WIDTH     = 31,
  parameter int Y_DATA_WIDTH_INT = 1
) (
  input  logic [X_DATA_WIDTH-1:0] x,
  input  logic                    round_mode,
  output logic [Y_DATA_WIDTH-1:0] y,
  output logic                    sat
);

  localparam int DROP = (X_DATA_WIDTH - X_DATA_WIDTH_INT) - (Y_DATA_WIDTH - Y_DATA_WIDTH_INT);
  localparam int QW   = X_DATA_WIDTH - DROP + 1;
  localparam logic [MAX_W-1:0] POS_FULL = sat_pos_limit(Y_DATA_WIDTH);
  localparam logic [MAX_W-1:0] NEG_FULL = sat_neg_limit(Y_DATA_WIDTH);
  localparam logic [Y_DATA_WIDTH-1:0] POS_LIM = POS_FULL[Y_DATA_WIDTH-1:0];
  localparam logic [Y_DATA_WIDTH-1:0] NEG_LIM = NEG_FULL[Y_DATA_WIDTH-1:0];

  logic                      round_up;
  logic [QW-1:0]             q;
  logic [QW-Y_DATA_WIDTH:0]  q_hi;
  logic                      ovf;
  logic                      unused_frac;

  // Adding half an LSB before flooring equals adding the top dropped bit after.
  assign round_up    = (round_mode == ROUND_HALF_UP) && x[DROP-1];
  assign q           = {x[X_DATA_WIDTH-1], x[X_DATA_WIDTH-1:DROP]} + QW'(round_up);
  assign q_hi        = q[QW-1:Y_DATA_WIDTH-1];
  assign ovf         = !((&q_hi) || !(|q_hi));
  assign unused_frac = ^x[DROP-1:0];

  always_comb begin
    y   = q[Y_DATA_WIDTH-1:0];
    sat = ovf;
    if (ovf) y = q[QW-1] ? NEG_LIM : POS_LIM;
  end

endmodule

// File: rtl/convert_fixed_point_shrink_stream.sv
// Multi-lane fixed-point shrink with a 2-stage valid/ready pipeline and saturation tracking.
// Optional saturation event counter: define CONVERT_FIXED_POINT_SAT_COUNT_EN.
module convert_fixed_point_shrink_stream
  import fixed_point_pkg::*;
#(
  parameter int X_DATA_WIDTH     = 47,
  parameter int X_DATA_WIDTH_INT = 5,
  parameter int Y_DATA_WIDTH     = 31,
  parameter int Y_DATA_WIDTH_INT = 1,
  parameter int CHANNELS         = 2,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [CHANNELS*X_DATA_WIDTH-1:0] s_data,
  input  logic                           round_mode,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CHANNELS*Y_DATA_WIDTH-1:0] m_data,
  output logic [CHANNELS-1:0]            m_sat,
  output logic [CHANNELS-1:0]            sat_sticky,
  input  logic                           sat_clear,
  output logic [CNT_WIDTH-1:0]           sat_count
);

  localparam int X_FRAC = X_DATA_WIDTH - X_DATA_WIDTH_INT;
  localparam int Y_FRAC = Y_DATA_WIDTH - Y_DATA_WIDTH_INT;

  generate
    if ((X_DATA_WIDTH_INT < Y_DATA_WIDTH_INT) || (X_FRAC < Y_FRAC + 1)) begin : g_param_err
      $error("convert_fixed_point_shrink_stream: output format must be narrower in both fields");
    end
  endgenerate

  logic                             pipe_en;
  logic [CHANNELS*Y_DATA_WIDTH-1:0] lane_y;
  logic [CHANNELS-1:0]              lane_sat;

  logic                             s1_valid_reg;
  logic [CHANNELS*Y_DATA_WIDTH-1:0] s1_data_reg;
  logic [CHANNELS-1:0]              s1_sat_reg;
  logic                             m_valid_reg;
  logic [CHANNELS*Y_DATA_WIDTH-1:0] m_data_reg;
  logic [CHANNELS-1:0]              m_sat_reg;
  logic [CHANNELS-1:0]              sticky_reg;
  logic [CHANNELS-1:0]              sat_hit;

  // Whole pipeline moves together; a stalled output freezes both stages.
  assign pipe_en    = !m_valid_reg || m_ready;
  assign s_ready    = pipe_en;
  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;
  assign m_sat      = m_sat_reg;
  assign sat_sticky = sticky_reg;
  assign sat_hit    = (m_valid_reg && m_ready) ? m_sat_reg : '0;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      convert_fixed_point_shrink_lane #(
        .X_DATA_WIDTH    (X_DATA_WIDTH),
        .X_DATA_WIDTH_INT(X_DATA_WIDTH_INT),
        .Y_DATA_WIDTH    (Y_DATA_WIDTH),
        .Y_DATA_WIDTH_INT(Y_DATA_WIDTH_INT)
      ) u_lane (
        .x         (s_data[gi*X_DATA_WIDTH +: X_DATA_WIDTH]),
        .round_mode(round_mode),
        .y         (lane_y[gi*Y_DATA_WIDTH +: Y_DATA_WIDTH]),
        .sat       (lane_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_sat_reg   <= '0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_sat_reg    <= '0;
    end else if (pipe_en) begin
      s1_valid_reg <= s_valid;
      s1_data_reg  <= lane_y;
      s1_sat_reg   <= lane_sat;
      m_valid_reg  <= s1_valid_reg;
      m_data_reg   <= s1_data_reg;
      m_sat_reg    <= s1_sat_reg;
    end
  end

  // A saturating transfer in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_reg <= '0;
    else if (sat_clear) sticky_reg <= sat_hit;
    else sticky_reg <= sticky_reg | sat_hit;
  end

`ifdef CONVERT_FIXED_POINT_SAT_COUNT_EN
  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_reg <= '0;
    else if (sat_clear) count_reg <= (|sat_hit) ? CNT_WIDTH'(1) : '0;
    else if ((|sat_hit) && !(&count_reg)) count_reg <= count_reg + 1'b1;
  end

  assign sat_count = count_reg;
`else
  assign sat_count = '0;
`endif

endmodule
